// File: rtl/divider.sv
// Sequential signed restoring divider: one quotient bit per clock, fixed latency.
// Quotient truncates toward zero; remainder takes the dividend's sign.
module divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             done_o,
  output logic             busy_o,
  output logic             dbz_o,
  output logic             ovf_o
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StPrep, StIter, StFix} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] dividend_q, divisor_q;
  logic             neg_n_q, neg_d_q;
  logic [WIDTH-1:0] mag_d_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH:0]   rem_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;
  logic             done_q, dbz_q, ovf_q;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             is_dbz, is_ovf;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start_i) state_d = StPrep;
      StPrep: state_d = StIter;
      StIter: if (cnt_q == LastCnt) state_d = StFix;
      StFix:  state_d = StIdle;
    endcase
  end

  // One restoring step: shift {R,Q} left, trial-subtract |D|; plus special-case decode.
  always_comb begin
    rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, mag_d_q};
    is_dbz = (divisor_q == '0);
    is_ovf = (dividend_q == MinVal) && (divisor_q == '1);
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Datapath and registered result outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dividend_q  <= '0;
      divisor_q   <= '0;
      neg_n_q     <= 1'b0;
      neg_d_q     <= 1'b0;
      mag_d_q     <= '0;
      quo_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      done_q <= (state_q == StFix);
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            dividend_q <= dividend_i;
            divisor_q  <= divisor_i;
            neg_n_q    <= dividend_i[WIDTH-1];
            neg_d_q    <= divisor_i[WIDTH-1];
          end
        end
        StPrep: begin
          // Negating the most negative value yields itself, i.e. 2^(WIDTH-1) unsigned.
          quo_q   <= neg_n_q ? -dividend_q : dividend_q;
          mag_d_q <= neg_d_q ? -divisor_q : divisor_q;
          rem_q   <= '0;
          cnt_q   <= '0;
        end
        StIter: begin
          if (!trial[WIDTH]) begin
            rem_q <= trial;
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= rem_sh;
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q + 1'b1;
        end
        StFix: begin
          if (is_dbz) begin
            quotient_q  <= '1;
            remainder_q <= dividend_q;
            dbz_q       <= 1'b1;
            ovf_q       <= 1'b0;
          end else if (is_ovf) begin
            quotient_q  <= MinVal;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b1;
          end else begin
            quotient_q  <= (neg_n_q ^ neg_d_q) ? -quo_q : quo_q;
            remainder_q <= neg_n_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
          end
        end
      endcase
    end
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign done_o      = done_q;
  assign busy_o      = (state_q != StIdle);
  assign dbz_o       = dbz_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider (WIDTH=8): directed cases, handshake/reset cases,
// then random operands checked against an integer-arithmetic reference.
module tb_divider;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic [7:0] quotient, remainder;
  logic       done, busy, dbz, ovf;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;

  divider #(.WIDTH(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .dividend_i (dividend),
    .divisor_i  (divisor),
    .quotient_o (quotient),
    .remainder_o(remainder),
    .done_o     (done),
    .busy_o     (busy),
    .dbz_o      (dbz),
    .ovf_o      (ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed integer division with the special cases layered on top.
  task automatic model(input logic [7:0] n, input logic [7:0] d,
                       output logic [7:0] q, output logic [7:0] r,
                       output logic ez, output logic ov);
    int ni, di, qi, ri;
    ni = $signed(n);
    di = $signed(d);
    ez = 1'b0;
    ov = 1'b0;
    if (di == 0) begin
      qi = -1; ri = ni; ez = 1'b1;
    end else if (ni == -128 && di == -1) begin
      qi = 128; ri = 0; ov = 1'b1;
    end else begin
      qi = ni / di; ri = ni % di;
    end
    q = qi[7:0];
    r = ri[7:0];
  endtask

  // Drive a start for one edge; returns with the sample point just after the accepting edge.
  task automatic launch(input logic [7:0] n, input logic [7:0] d);
    @(negedge clk);
    start = 1'b1; dividend = n; divisor = d;
    @(posedge clk); #1;
    acc_cyc = cyc;
    start = 1'b0;
  endtask

  // Waits for done_o (bounded); lat = edges after the accepting edge, -1 on timeout.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = -1;
    busy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy) busy_cnt++;
      @(posedge clk); #1;
      if (done) begin
        lat = cyc - acc_cyc;
        break;
      end
    end
  endtask

  task automatic chk_result(input string tag, input logic [7:0] n, input logic [7:0] d);
    logic [7:0] q, r;
    logic ez, ov;
    model(n, d, q, r, ez, ov);
    chk({tag, ".q"}, int'(quotient), int'(q));
    chk({tag, ".r"}, int'(remainder), int'(r));
    chk({tag, ".dbz"}, int'(dbz), int'(ez));
    chk({tag, ".ovf"}, int'(ovf), int'(ov));
  endtask

  // Full operation: latency 10 edges after acceptance (done seen at the 11th edge counting
  // the accepting one), busy for 10 cycles, one-cycle done pulse.
  task automatic run(input string tag, input logic [7:0] n, input logic [7:0] d);
    int lat, bc;
    launch(n, d);
    wait_done(lat, bc);
    chk({tag, ".lat"}, lat, 10);
    chk({tag, ".busy_cycles"}, bc, 10);
    chk({tag, ".busy_at_done"}, int'(busy), 0);
    chk_result(tag, n, d);
    @(posedge clk); #1;
    chk({tag, ".done_fall"}, int'(done), 0);
  endtask

  initial begin
    int lat, bc, seen;
    logic [7:0] rn, rd;

    #1;
    chk("rst.q", int'(quotient), 0);
    chk("rst.r", int'(remainder), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.dbz", int'(dbz), 0);
    chk("rst.ovf", int'(ovf), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run("p100_7", 8'd100, 8'd7);
    chk("p100_7.q_lit", int'(quotient), 'h0E);
    chk("p100_7.r_lit", int'(remainder), 'h02);
    run("m100_7", 8'h9C, 8'd7);
    run("p100_m7", 8'd100, 8'hF9);
    run("m100_m7", 8'h9C, 8'hF9);
    run("p5_9", 8'd5, 8'd9);
    run("p37_0", 8'd37, 8'd0);
    chk("p37_0.q_lit", int'(quotient), 'hFF);
    run("min_m1", 8'h80, 8'hFF);
    chk("min_m1.q_lit", int'(quotient), 'h80);
    run("min_1", 8'h80, 8'h01);
    run("min_min", 8'h80, 8'h80);
    run("p127_min", 8'h7F, 8'h80);

    // start pulsed mid-operation must be ignored.
    launch(8'd50, 8'd3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1; dividend = 8'd99; divisor = 8'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    chk("ignore.lat", lat, 10);
    chk("ignore.q", int'(quotient), 'h10);
    chk("ignore.r", int'(remainder), 'h02);

    // start held during the done cycle is accepted back-to-back.
    start = 1'b1; dividend = 8'd9; divisor = 8'd2;
    @(posedge clk); #1;
    acc_cyc = cyc;
    start = 1'b0;
    chk("b2b.busy", int'(busy), 1);
    wait_done(lat, bc);
    chk("b2b.lat", lat, 10);
    chk("b2b.q", int'(quotient), 'h04);
    chk("b2b.r", int'(remainder), 'h01);

    // Reset between edges 5 and 6 of an operation clears everything at once.
    run("pre_rst", 8'h9C, 8'hF9);
    launch(8'd100, 8'd7);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst.q", int'(quotient), 0);
    chk("mid_rst.r", int'(remainder), 0);
    chk("mid_rst.done", int'(done), 0);
    chk("mid_rst.busy", int'(busy), 0);
    chk("mid_rst.dbz", int'(dbz), 0);
    chk("mid_rst.ovf", int'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk("mid_rst.no_done", seen, 0);
    run("post_rst", 8'd20, 8'd6);
    chk("post_rst.q_lit", int'(quotient), 'h03);
    chk("post_rst.r_lit", int'(remainder), 'h02);

    // Random operands, with occasional zero divisor and extreme dividend.
    for (int i = 0; i < 60; i++) begin
      rn = 8'($urandom);
      rd = 8'($urandom);
      if ($urandom_range(0, 9) == 0) rd = 8'h00;
      if ($urandom_range(0, 9) == 0) rn = 8'h80;
      if ($urandom_range(0, 14) == 0) rd = 8'hFF;
      run($sformatf("rnd%0d", i), rn, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
